hls_exec_status_monitor: RTL and testbench
==========================================

// Module: hls_exec_status_monitor
// PURPOSE
// Synthesizable execution monitor for one HLS-generated module and one of its pipelined loops.
// It tracks the module ap_start/ap_ready/ap_done/ap_continue handshake.
// It also decodes the loop FSM (cur_state versus the iteration start/end state codes) to count
// invocations, iterations and stall cycles. It sits beside the DUT in simulation or on-chip debug
// and exposes saturating counters that freeze when finish is seen.
// PARAMETERS
// STATE_W  15  width of the monitored loop FSM state vector (one-hot)
// CNT_W    32  width of every counter output
// PORTS
// clock              in   1        single clock; all logic on posedge
// reset              in   1        asynchronous, active-low reset
// ap_start           in   1        module start request
// ap_ready           in   1        module ready to accept the next start
// ap_done            in   1        module transaction complete
// ap_continue        in   1        downstream accepts done (tie 1 when unused)
// finish             in   1        end of test; freezes all counters
// cur_state          in   STATE_W  loop FSM current state
// iter_start_state   in   STATE_W  state code where an iteration begins
// iter_end_state     in   STATE_W  state code where an iteration ends
// iter_start_block   in   1        stall qualifier in the start state
// iter_end_block     in   1        stall qualifier in the end state
// iter_start_enable  in   1        pipeline-stage enable for the start state
// iter_end_enable    in   1        pipeline-stage enable for the end state
// loop_start         in   1        loop invocation request
// loop_done          in   1        loop invocation complete
// module_busy        out  1        module tracker not in IDLE
// loop_active        out  1        loop tracker in L_RUN
// start_cnt          out  CNT_W    accepted module starts
// done_cnt           out  CNT_W    completed module transactions
// active_cycles      out  CNT_W    cycles with module_busy=1
// loop_inv_cnt       out  CNT_W    loop invocations
// iter_start_cnt     out  CNT_W    iteration start events
// iter_end_cnt       out  CNT_W    iteration end events
// stall_cycles       out  CNT_W    blocked cycles in the start or end state
// last_trip          out  CNT_W    iter_end_cnt delta of the last finished invocation
// frozen             out  1        sticky; set the cycle after finish=1
// BEHAVIOUR
// - Reset: all outputs 0; trackers go to IDLE/L_IDLE.
// - Outputs are registered, so an event appears 1 cycle after the sampling edge.
// - Module FSM states are IDLE, RUN and WAIT_CONT.
//   - IDLE, ap_start=1: go to RUN; start_cnt++.
//   - RUN, ap_done=1 and ap_continue=1: done_cnt++.
//     Stay in RUN and increment start_cnt if ap_start=1 in the same cycle; otherwise go to IDLE.
//   - RUN, ap_done=1 and ap_continue=0: go to WAIT_CONT; done_cnt++.
//   - WAIT_CONT, ap_continue=1: go to IDLE, or to RUN with start_cnt++ if ap_start=1.
//   - ap_ready is informational only and does not change state.
//   - active_cycles++ every cycle the state is not IDLE.
// - Start event (st_ev) = full-vector match cur_state==iter_start_state, and iter_start_enable=1,
//   and iter_start_block=0.
// - End event (en_ev) = the same check using iter_end_state, iter_end_enable and iter_end_block.
// - Loop FSM states are L_IDLE and L_RUN.
//   - L_IDLE, loop_start=1: go to L_RUN; loop_inv_cnt++; clear the trip base register.
//   - L_RUN: st_ev gives iter_start_cnt++; en_ev gives iter_end_cnt++ and trip++.
//     When a state match and its enable hold while its block=1, stall_cycles++ (once per cycle).
//   - L_RUN, loop_done=1: last_trip takes the trip value, counting an en_ev in that same cycle.
//     Go to L_IDLE, unless loop_start=1 in the same cycle: then stay in L_RUN, loop_inv_cnt++, trip=0.
// - Simultaneous st_ev and en_ev in one cycle: both counters increment.
//   When both state codes are equal, one matching cycle counts both.
// - Counters saturate at all-ones and never wrap.
// - finish=1 sampled at a posedge: frozen=1 from the next cycle.
//   All counters and FSMs hold until reset; frozen clears only on reset.
// - Reset is asynchronous at any time, including mid-operation, and clears everything immediately.
// TESTING
// - Reset: hold reset=0 with random inputs -> all outputs 0; release -> stays 0 with inputs idle.
// - Module txn: ap_start 1 cycle, ap_done 5 cycles later with ap_continue=1
//   -> start_cnt=1, done_cnt=1, active_cycles=5, module_busy=0.
// - Back-to-back: ap_done and ap_start together in RUN -> done_cnt=1, start_cnt=2, busy stays 1.
//   ap_continue=0 on ap_done -> busy stays 1 until ap_continue.
// - Loop: loop_start, then 4 st_ev and 4 en_ev, 2 cycles of block=1 in the end state, then loop_done
//   -> loop_inv_cnt=1, iter counts 4/4, stall_cycles=2, last_trip=4.
// - Saturation: with CNT_W=4, 20 module txns -> start_cnt=done_cnt=15.
// - Finish/freeze: assert finish mid-loop -> frozen=1 next cycle and counters hold;
//   mid-txn reset=0 -> all zero.

Source files
------------

// File: rtl/hls_exec_status_monitor.sv
// Execution monitor for an HLS module handshake and one pipelined loop FSM.
// All counters saturate and freeze once finish has been seen.
module hls_exec_status_monitor #(
  parameter int STATE_W = 15,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic               finish,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               loop_start,
  input  logic               loop_done,
  output logic               module_busy,
  output logic               loop_active,
  output logic [CNT_W-1:0]   start_cnt,
  output logic [CNT_W-1:0]   done_cnt,
  output logic [CNT_W-1:0]   active_cycles,
  output logic [CNT_W-1:0]   loop_inv_cnt,
  output logic [CNT_W-1:0]   iter_start_cnt,
  output logic [CNT_W-1:0]   iter_end_cnt,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   last_trip,
  output logic               frozen
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT_CONT = 2'd2} mod_state_e;
  typedef enum logic {L_IDLE = 1'b0, L_RUN = 1'b1} loop_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  mod_state_e  mod_q, mod_d;
  loop_state_e loop_q, loop_d;
  logic [CNT_W-1:0] start_q, start_d, done_q, done_d, active_q, active_d;
  logic [CNT_W-1:0] inv_q, inv_d, ist_q, ist_d, ien_q, ien_d;
  logic [CNT_W-1:0] stall_q, stall_d, trip_q, trip_d, last_q, last_d;
  logic busy_q, busy_d, lact_q, lact_d, frozen_q, frozen_d;

  logic st_match_s, en_match_s, st_ev_s, en_ev_s, stall_s, hold_s;

  assign st_match_s = (cur_state == iter_start_state);
  assign en_match_s = (cur_state == iter_end_state);
  assign st_ev_s    = st_match_s & iter_start_enable & ~iter_start_block;
  assign en_ev_s    = en_match_s & iter_end_enable & ~iter_end_block;
  assign stall_s    = (st_match_s & iter_start_enable & iter_start_block) |
                      (en_match_s & iter_end_enable & iter_end_block);
  // finish in the current cycle already suppresses this cycle's update
  assign hold_s     = finish | frozen_q;

  always_comb begin
    mod_d    = mod_q;
    loop_d   = loop_q;
    start_d  = start_q;
    done_d   = done_q;
    active_d = active_q;
    inv_d    = inv_q;
    ist_d    = ist_q;
    ien_d    = ien_q;
    stall_d  = stall_q;
    trip_d   = trip_q;
    last_d   = last_q;
    frozen_d = frozen_q | finish;
    if (hold_s) begin
      mod_d  = mod_q;
      loop_d = loop_q;
    end else begin
      if (mod_q != IDLE) active_d = sat_inc(active_q);
      else               active_d = active_q;

      case (mod_q)
        IDLE: begin
          if (ap_start) begin
            mod_d   = RUN;
            start_d = sat_inc(start_q);
          end else begin
            mod_d = IDLE;
          end
        end
        RUN: begin
          if (ap_done) begin
            done_d = sat_inc(done_q);
            if (!ap_continue) begin
              mod_d = WAIT_CONT;
            end else if (ap_start) begin
              mod_d   = RUN;
              start_d = sat_inc(start_q);
            end else begin
              mod_d = IDLE;
            end
          end else begin
            mod_d = RUN;
          end
        end
        WAIT_CONT: begin
          if (ap_continue) begin
            if (ap_start) begin
              mod_d   = RUN;
              start_d = sat_inc(start_q);
            end else begin
              mod_d = IDLE;
            end
          end else begin
            mod_d = WAIT_CONT;
          end
        end
        default: mod_d = IDLE;
      endcase

      case (loop_q)
        L_IDLE: begin
          if (loop_start) begin
            loop_d = L_RUN;
            inv_d  = sat_inc(inv_q);
            trip_d = {CNT_W{1'b0}};
          end else begin
            loop_d = L_IDLE;
          end
        end
        L_RUN: begin
          if (st_ev_s) ist_d = sat_inc(ist_q);
          else         ist_d = ist_q;
          if (en_ev_s) begin
            ien_d  = sat_inc(ien_q);
            trip_d = sat_inc(trip_q);
          end else begin
            ien_d  = ien_q;
            trip_d = trip_q;
          end
          if (stall_s) stall_d = sat_inc(stall_q);
          else         stall_d = stall_q;
          // trip_d already includes an end event of this same cycle
          if (loop_done) begin
            last_d = trip_d;
            if (loop_start) begin
              loop_d = L_RUN;
              inv_d  = sat_inc(inv_q);
              trip_d = {CNT_W{1'b0}};
            end else begin
              loop_d = L_IDLE;
            end
          end else begin
            loop_d = L_RUN;
          end
        end
        default: loop_d = L_IDLE;
      endcase
    end
    busy_d = (mod_d != IDLE);
    lact_d = (loop_d == L_RUN);
  end

  // state, counters and registered status flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mod_q    <= IDLE;
      loop_q   <= L_IDLE;
      start_q  <= {CNT_W{1'b0}};
      done_q   <= {CNT_W{1'b0}};
      active_q <= {CNT_W{1'b0}};
      inv_q    <= {CNT_W{1'b0}};
      ist_q    <= {CNT_W{1'b0}};
      ien_q    <= {CNT_W{1'b0}};
      stall_q  <= {CNT_W{1'b0}};
      trip_q   <= {CNT_W{1'b0}};
      last_q   <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      lact_q   <= 1'b0;
      frozen_q <= 1'b0;
    end else begin
      mod_q    <= mod_d;
      loop_q   <= loop_d;
      start_q  <= start_d;
      done_q   <= done_d;
      active_q <= active_d;
      inv_q    <= inv_d;
      ist_q    <= ist_d;
      ien_q    <= ien_d;
      stall_q  <= stall_d;
      trip_q   <= trip_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      lact_q   <= lact_d;
      frozen_q <= frozen_d;
    end
  end

  assign module_busy    = busy_q;
  assign loop_active    = lact_q;
  assign start_cnt      = start_q;
  assign done_cnt       = done_q;
  assign active_cycles  = active_q;
  assign loop_inv_cnt   = inv_q;
  assign iter_start_cnt = ist_q;
  assign iter_end_cnt   = ien_q;
  assign stall_cycles   = stall_q;
  assign last_trip      = last_q;
  assign frozen         = frozen_q;

  logic unused_s;
  assign unused_s = ap_ready;

endmodule

// File: tb/tb_hls_exec_status_monitor.sv
// Directed bench for hls_exec_status_monitor: expectations are queued with the stimulus
// and popped/compared one cycle later, after the sampling edge.
module tb_hls_exec_status_monitor;
  localparam int SW = 15;

  logic clock = 1'b0;
  logic reset;
  logic ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [SW-1:0] cur_state, iter_start_state, iter_end_state;
  logic iter_start_block, iter_end_block, iter_start_enable, iter_end_enable;
  logic loop_start, loop_done;

  logic        module_busy, loop_active, frozen;
  logic [31:0] start_cnt, done_cnt, active_cycles, loop_inv_cnt;
  logic [31:0] iter_start_cnt, iter_end_cnt, stall_cycles, last_trip;

  logic        s_busy, s_lact, s_frozen;
  logic [3:0]  s_start, s_done, s_active, s_inv, s_ist, s_ien, s_stall, s_last;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  hls_exec_status_monitor #(.STATE_W(SW), .CNT_W(32)) u_dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .cur_state(cur_state), .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .loop_start(loop_start), .loop_done(loop_done),
    .module_busy(module_busy), .loop_active(loop_active), .start_cnt(start_cnt),
    .done_cnt(done_cnt), .active_cycles(active_cycles), .loop_inv_cnt(loop_inv_cnt),
    .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
    .stall_cycles(stall_cycles), .last_trip(last_trip), .frozen(frozen)
  );

  hls_exec_status_monitor #(.STATE_W(SW), .CNT_W(4)) u_sat (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .cur_state(cur_state), .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .loop_start(loop_start), .loop_done(loop_done),
    .module_busy(s_busy), .loop_active(s_lact), .start_cnt(s_start),
    .done_cnt(s_done), .active_cycles(s_active), .loop_inv_cnt(s_inv),
    .iter_start_cnt(s_ist), .iter_end_cnt(s_ien),
    .stall_cycles(s_stall), .last_trip(s_last), .frozen(s_frozen)
  );

  localparam int O_BUSY = 0, O_LACT = 1, O_START = 2, O_DONE = 3, O_ACT = 4, O_INV = 5;
  localparam int O_IST = 6, O_IEN = 7, O_STALL = 8, O_LAST = 9, O_FROZEN = 10;
  localparam int O_SSTART = 11, O_SDONE = 12, O_SACT = 13;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      O_BUSY:   return {31'd0, module_busy};
      O_LACT:   return {31'd0, loop_active};
      O_START:  return start_cnt;
      O_DONE:   return done_cnt;
      O_ACT:    return active_cycles;
      O_INV:    return loop_inv_cnt;
      O_IST:    return iter_start_cnt;
      O_IEN:    return iter_end_cnt;
      O_STALL:  return stall_cycles;
      O_LAST:   return last_trip;
      O_FROZEN: return {31'd0, frozen};
      O_SSTART: return {28'd0, s_start};
      O_SDONE:  return {28'd0, s_done};
      O_SACT:   return {28'd0, s_active};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic expect_zero(input string tag);
    for (int i = 0; i <= O_FROZEN; i++) expect_val(tag, i, 32'd0);
  endtask

  task automatic check_sb();
    exp_t e;
    logic [31:0] o;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s[%0d]: observed %0d expected %0d", e.tag, e.sel, o, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b1; finish = 1'b0;
    cur_state = 15'h0000; iter_start_state = 15'h0002; iter_end_state = 15'h0008;
    iter_start_block = 1'b0; iter_end_block = 1'b0;
    iter_start_enable = 1'b0; iter_end_enable = 1'b0;
    loop_start = 1'b0; loop_done = 1'b0;
  endtask

  task automatic drive_st();
    cur_state = 15'h0002; iter_start_enable = 1'b1; iter_end_enable = 1'b0;
    iter_end_block = 1'b0;
  endtask

  task automatic drive_en(input logic blk);
    cur_state = 15'h0008; iter_start_enable = 1'b0; iter_end_enable = 1'b1;
    iter_end_block = blk;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    // reset held with random activity on every input
    for (int i = 0; i < 6; i++) begin
      ap_start = 1'($urandom); ap_done = 1'($urandom); ap_continue = 1'($urandom);
      finish = 1'($urandom); cur_state = 15'($urandom);
      iter_start_state = 15'($urandom); iter_end_state = 15'($urandom);
      iter_start_block = 1'($urandom); iter_end_block = 1'($urandom);
      iter_start_enable = 1'($urandom); iter_end_enable = 1'($urandom);
      loop_start = 1'($urandom); loop_done = 1'($urandom);
      step();
    end
    expect_zero("rst_hold");
    check_sb();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    expect_zero("rst_rel");
    check_sb();

    // single module transaction, done 5 cycles after start
    ap_start = 1'b1;
    expect_val("txn_busy", O_BUSY, 32'd1);
    step(); check_sb();
    ap_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    ap_done = 1'b1;
    expect_val("txn_start", O_START, 32'd1);
    expect_val("txn_done", O_DONE, 32'd1);
    expect_val("txn_act", O_ACT, 32'd5);
    expect_val("txn_busy0", O_BUSY, 32'd0);
    step(); check_sb();
    ap_done = 1'b0;

    // back-to-back done+start in RUN
    ap_start = 1'b1; step();
    ap_start = 1'b0; step();
    ap_done = 1'b1; ap_start = 1'b1;
    expect_val("b2b_done", O_DONE, 32'd2);
    expect_val("b2b_start", O_START, 32'd3);
    expect_val("b2b_busy", O_BUSY, 32'd1);
    step(); check_sb();
    // done without continue parks in WAIT_CONT
    ap_start = 1'b0; ap_continue = 1'b0;
    step();
    ap_done = 1'b0;
    expect_val("wc_busy", O_BUSY, 32'd1);
    expect_val("wc_done", O_DONE, 32'd3);
    step(); check_sb();
    ap_continue = 1'b1;
    expect_val("wc_rel_busy", O_BUSY, 32'd0);
    expect_val("wc_rel_act", O_ACT, 32'd10);
    step(); check_sb();
    // WAIT_CONT released together with a new start
    ap_start = 1'b1; step();
    ap_start = 1'b0; ap_done = 1'b1; ap_continue = 1'b0; step();
    ap_done = 1'b0; ap_continue = 1'b1; ap_start = 1'b1;
    expect_val("wc_start", O_START, 32'd5);
    expect_val("wc_start_busy", O_BUSY, 32'd1);
    step(); check_sb();
    ap_start = 1'b0; ap_done = 1'b1;
    expect_val("wc2_done", O_DONE, 32'd5);
    expect_val("wc2_act", O_ACT, 32'd13);
    expect_val("wc2_busy", O_BUSY, 32'd0);
    step(); check_sb();
    ap_done = 1'b0;

    // loop: 4 iterations, 2 blocked cycles in the end state
    loop_start = 1'b1;
    expect_val("lp_active", O_LACT, 32'd1);
    expect_val("lp_inv", O_INV, 32'd1);
    step(); check_sb();
    loop_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_st(); step();
      if (i == 3) begin
        drive_en(1'b1); step(); step();
      end
      drive_en(1'b0); step();
    end
    idle_inputs();
    loop_done = 1'b1;
    expect_val("lp_ist", O_IST, 32'd4);
    expect_val("lp_ien", O_IEN, 32'd4);
    expect_val("lp_stall", O_STALL, 32'd2);
    expect_val("lp_trip", O_LAST, 32'd4);
    expect_val("lp_idle", O_LACT, 32'd0);
    step(); check_sb();
    loop_done = 1'b0;

    // done+start with an end event in the same cycle, then shared state code
    loop_start = 1'b1; step();
    loop_start = 1'b0; drive_en(1'b0); step();
    loop_done = 1'b1; loop_start = 1'b1;
    expect_val("rs_trip", O_LAST, 32'd2);
    expect_val("rs_inv", O_INV, 32'd3);
    expect_val("rs_active", O_LACT, 32'd1);
    expect_val("rs_ien", O_IEN, 32'd6);
    step(); check_sb();
    loop_done = 1'b0; loop_start = 1'b0;
    iter_end_state = 15'h0002; cur_state = 15'h0002;
    iter_start_enable = 1'b1; iter_end_enable = 1'b1;
    expect_val("eq_ist", O_IST, 32'd5);
    expect_val("eq_ien", O_IEN, 32'd7);
    step(); check_sb();
    idle_inputs();
    loop_done = 1'b1;
    expect_val("eq_trip", O_LAST, 32'd1);
    expect_val("eq_idle", O_LACT, 32'd0);
    step(); check_sb();
    loop_done = 1'b0;
    // events outside L_RUN are ignored
    drive_st();
    expect_val("idle_ist", O_IST, 32'd5);
    step(); check_sb();
    idle_inputs();

    // finish mid-loop freezes everything
    loop_start = 1'b1; step();
    loop_start = 1'b0; drive_st(); step();
    idle_inputs(); step();
    finish = 1'b1;
    expect_val("fz_set", O_FROZEN, 32'd1);
    step(); check_sb();
    finish = 1'b0; drive_st(); ap_start = 1'b1; loop_done = 1'b1;
    step(); step(); step();
    expect_val("fz_sticky", O_FROZEN, 32'd1);
    expect_val("fz_ist", O_IST, 32'd6);
    expect_val("fz_inv", O_INV, 32'd4);
    expect_val("fz_start", O_START, 32'd5);
    expect_val("fz_lact", O_LACT, 32'd1);
    expect_val("fz_busy", O_BUSY, 32'd0);
    expect_val("fz_act", O_ACT, 32'd13);
    check_sb();

    // asynchronous reset clears frozen state, then again mid-transaction
    #2 reset = 1'b0;
    #1;
    expect_zero("rst_frozen");
    check_sb();
    idle_inputs();
    reset = 1'b1;
    step();
    ap_start = 1'b1;
    expect_val("mt_start", O_START, 32'd1);
    expect_val("mt_busy", O_BUSY, 32'd1);
    step(); check_sb();
    ap_start = 1'b0; step();
    #2 reset = 1'b0;
    #1;
    expect_zero("rst_midtxn");
    check_sb();
    step();
    reset = 1'b1;
    step();

    // saturation with the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      ap_start = 1'b1; step();
      ap_start = 1'b0; ap_done = 1'b1; step();
      ap_done = 1'b0;
    end
    expect_val("sat_start", O_SSTART, 32'd15);
    expect_val("sat_done", O_SDONE, 32'd15);
    expect_val("sat_act", O_SACT, 32'd15);
    expect_val("wide_start", O_START, 32'd20);
    expect_val("wide_done", O_DONE, 32'd20);
    step(); check_sb();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
